dcache_miss_ctrl: RTL and testbench

- Memory-stage cache controller for the RV32I pipeline.
- Sits between M-stage control (load/store, address), the direct-mapped data cache array (tag-match `cache_hit_i`) and the multi-cycle data memory (`mem_ready_i`).
- Sequences read-miss refill and write-through stores.
- Drives the global stall `StallAllM_o`, which holds the pipeline until the access completes.

---
 rtl/dcache_miss_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_dcache_miss_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_miss_ctrl.sv
// Memory-stage data cache controller: read-miss refill, write-through stores,
// global stall and sticky memory timeout. Optional perf counters: DCACHE_PERF_CNT_EN.
module dcache_miss_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemReadM_i,
  input  logic [2:0]        MemWriteM_i,
  input  logic [ADDR_W-1:0] ALUResultM_i,
  input  logic              cache_hit_i,
  input  logic              mem_ready_i,
  output logic              mem_req_o,
  output logic [2:0]        mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              cache_fill_o,
  output logic              cache_wr_o,
  output logic              StallAllM_o,
  output logic              err_o
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    FILL    = 2'd2,
    WR_THRU = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};

  state_t            state_r;
  state_t            state_s;
  logic [ADDR_W-1:0] addr_r;
  logic [2:0]        we_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic              err_r;
  logic              store_s;
  logic              rd_miss_s;
  logic              waiting_s;
  logic              timeout_s;

  assign store_s    = (MemWriteM_i != 3'b000);
  assign rd_miss_s  = ~store_s & MemReadM_i & ~cache_hit_i;
  assign waiting_s  = ((state_r == RD_MISS) || (state_r == WR_THRU)) && !mem_ready_i;
  assign cnt_nxt_s  = cnt_r + CNT_W'(1);
  // A completion in the cycle the count would reach TIMEOUT wins over the error.
  assign timeout_s  = waiting_s && (cnt_r != CNT_MAX_C) && (cnt_nxt_s == TIMEOUT_C);

  assign mem_addr_o = addr_r;
  assign mem_we_o   = we_r;
  assign err_o      = err_r;

  // Next-state and Mealy output decode; everything is forced low while in reset.
  always_comb begin
    state_s      = state_r;
    mem_req_o    = 1'b0;
    cache_fill_o = 1'b0;
    cache_wr_o   = 1'b0;
    StallAllM_o  = 1'b0;
    if (rst) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (store_s) begin
            cache_wr_o  = cache_hit_i;
            StallAllM_o = 1'b1;
            state_s     = WR_THRU;
          end else if (rd_miss_s) begin
            StallAllM_o = 1'b1;
            state_s     = RD_MISS;
          end else begin
            state_s = IDLE;
          end
        end
        RD_MISS: begin
          mem_req_o   = 1'b1;
          StallAllM_o = 1'b1;
          if (mem_ready_i) begin
            state_s = FILL;
          end else begin
            state_s = RD_MISS;
          end
        end
        FILL: begin
          cache_fill_o = 1'b1;
          StallAllM_o  = 1'b1;
          state_s      = IDLE;
        end
        WR_THRU: begin
          mem_req_o   = 1'b1;
          StallAllM_o = ~mem_ready_i;
          if (mem_ready_i) begin
            state_s = IDLE;
          end else begin
            state_s = WR_THRU;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request address/type capture, only when a new request is launched from IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r <= '0;
      we_r   <= 3'b000;
    end else if ((state_r == IDLE) && store_s) begin
      addr_r <= ALUResultM_i;
      we_r   <= MemWriteM_i;
    end else if ((state_r == IDLE) && rd_miss_s) begin
      addr_r <= ALUResultM_i;
      we_r   <= 3'b000;
    end else begin
      addr_r <= addr_r;
      we_r   <= we_r;
    end
  end

  // Saturating wait counter, cleared on every request launch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if ((state_r == IDLE) && (store_s || rd_miss_s)) begin
      cnt_r <= '0;
    end else if (waiting_s && (cnt_r != CNT_MAX_C)) begin
      cnt_r <= cnt_nxt_s;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Sticky timeout flag; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (timeout_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  logic refill_r;

  // Marks the IDLE cycle right after a refill, where the held load re-hits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refill_r <= 1'b0;
    end else begin
      refill_r <= (state_r == FILL);
    end
  end

  // Hit/miss event counters, wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_o  <= 32'd0;
      miss_cnt_o <= 32'd0;
    end else begin
      if ((state_r == IDLE) && !store_s && MemReadM_i && cache_hit_i && !refill_r) begin
        hit_cnt_o <= hit_cnt_o + 32'd1;
      end else begin
        hit_cnt_o <= hit_cnt_o;
      end
      if ((state_r == IDLE) && rd_miss_s) begin
        miss_cnt_o <= miss_cnt_o + 32'd1;
      end else begin
        miss_cnt_o <= miss_cnt_o;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Randomized transaction-level bench for dcache_miss_ctrl: expected behaviour
// comes from per-access rules (stall length, request window, fill pulse, timeout).
module tb_dcache_miss_ctrl;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              MemReadM_i;
  logic [2:0]        MemWriteM_i;
  logic [ADDR_W-1:0] ALUResultM_i;
  logic              cache_hit_i;
  logic              mem_ready_i;
  logic              mem_req_o;
  logic [2:0]        mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              cache_fill_o;
  logic              cache_wr_o;
  logic              StallAllM_o;
  logic              err_o;

  int   n_cmp   = 0;
  int   n_err   = 0;
  logic exp_err = 1'b0;

  dcache_miss_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
    .clk          (clk),
    .rst          (rst),
    .MemReadM_i   (MemReadM_i),
    .MemWriteM_i  (MemWriteM_i),
    .ALUResultM_i (ALUResultM_i),
    .cache_hit_i  (cache_hit_i),
    .mem_ready_i  (mem_ready_i),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .cache_fill_o (cache_fill_o),
    .cache_wr_o   (cache_wr_o),
    .StallAllM_o  (StallAllM_o),
    .err_o        (err_o)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Inputs other than mem_ready_i are don't-care while a request is in flight.
  task automatic scramble();
    MemReadM_i   = 1'($urandom_range(0, 1));
    MemWriteM_i  = 3'($urandom_range(0, 7));
    ALUResultM_i = $urandom;
    cache_hit_i  = 1'($urandom_range(0, 1));
  endtask

  task automatic idle_cycle();
    MemReadM_i  = 1'b0;
    MemWriteM_i = 3'b000;
    ALUResultM_i = $urandom;
    cache_hit_i = 1'($urandom_range(0, 1));
    mem_ready_i = 1'($urandom_range(0, 1));
    settle();
    chk("idle_stall", 32'(StallAllM_o), 32'd0);
    chk("idle_req", 32'(mem_req_o), 32'd0);
    chk("idle_err", 32'(err_o), 32'(exp_err));
    step();
  endtask

  task automatic load_hit(input logic [31:0] a);
    MemReadM_i   = 1'b1;
    MemWriteM_i  = 3'b000;
    ALUResultM_i = a;
    cache_hit_i  = 1'b1;
    mem_ready_i  = 1'($urandom_range(0, 1));
    settle();
    chk("lh_stall", 32'(StallAllM_o), 32'd0);
    chk("lh_req", 32'(mem_req_o), 32'd0);
    chk("lh_fill", 32'(cache_fill_o), 32'd0);
    chk("lh_wr", 32'(cache_wr_o), 32'd0);
    chk("lh_err", 32'(err_o), 32'(exp_err));
    step();
  endtask

  // Miss of latency k: stall for 1 + k + 1 cycles, request over the k wait cycles,
  // one fill strobe, then the held load re-hits with no stall.
  task automatic load_miss(input logic [31:0] a, input int k);
    int stalls = 0;
    int fills  = 0;
    MemReadM_i   = 1'b1;
    MemWriteM_i  = 3'b000;
    ALUResultM_i = a;
    cache_hit_i  = 1'b0;
    mem_ready_i  = 1'($urandom_range(0, 1));
    settle();
    chk("lm_det_stall", 32'(StallAllM_o), 32'd1);
    chk("lm_det_req", 32'(mem_req_o), 32'd0);
    chk("lm_det_wr", 32'(cache_wr_o), 32'd0);
    chk("lm_det_err", 32'(err_o), 32'(exp_err));
    if (StallAllM_o) stalls++;
    if (cache_fill_o) fills++;
    step();
    for (int i = 1; i <= k; i++) begin
      scramble();
      mem_ready_i = (i == k);
      settle();
      chk("lm_req", 32'(mem_req_o), 32'd1);
      chk("lm_addr", mem_addr_o, a);
      chk("lm_we", 32'(mem_we_o), 32'd0);
      chk("lm_err", 32'(err_o), 32'(exp_err));
      if (StallAllM_o) stalls++;
      if (cache_fill_o) fills++;
      if (i < k && i == TIMEOUT) exp_err = 1'b1;
      step();
    end
    scramble();
    mem_ready_i = 1'($urandom_range(0, 1));
    settle();
    chk("lm_fill", 32'(cache_fill_o), 32'd1);
    chk("lm_fill_req", 32'(mem_req_o), 32'd0);
    chk("lm_fill_addr", mem_addr_o, a);
    if (StallAllM_o) stalls++;
    if (cache_fill_o) fills++;
    step();
    MemReadM_i   = 1'b1;
    MemWriteM_i  = 3'b000;
    ALUResultM_i = a;
    cache_hit_i  = 1'b1;
    mem_ready_i  = 1'($urandom_range(0, 1));
    settle();
    chk("lm_rehit_req", 32'(mem_req_o), 32'd0);
    if (StallAllM_o) stalls++;
    if (cache_fill_o) fills++;
    step();
    chk("lm_stall_cycles", 32'(stalls), 32'(k + 2));
    chk("lm_fill_pulses", 32'(fills), 32'd1);
  endtask

  // Write-through of latency k: cache write only on hit, stall drops on completion.
  task automatic store(input logic [31:0] a, input logic [2:0] we, input logic hit, input int k);
    int wrs = 0;
    MemReadM_i   = 1'($urandom_range(0, 1));
    MemWriteM_i  = we;
    ALUResultM_i = a;
    cache_hit_i  = hit;
    mem_ready_i  = 1'($urandom_range(0, 1));
    settle();
    chk("st_det_stall", 32'(StallAllM_o), 32'd1);
    chk("st_det_req", 32'(mem_req_o), 32'd0);
    chk("st_det_fill", 32'(cache_fill_o), 32'd0);
    if (cache_wr_o) wrs++;
    step();
    for (int i = 1; i <= k; i++) begin
      scramble();
      mem_ready_i = (i == k);
      settle();
      chk("st_req", 32'(mem_req_o), 32'd1);
      chk("st_addr", mem_addr_o, a);
      chk("st_we", 32'(mem_we_o), 32'(we));
      chk("st_stall", 32'(StallAllM_o), 32'(i != k));
      chk("st_fill", 32'(cache_fill_o), 32'd0);
      chk("st_err", 32'(err_o), 32'(exp_err));
      if (cache_wr_o) wrs++;
      if (i < k && i == TIMEOUT) exp_err = 1'b1;
      step();
    end
    chk("st_wr_pulses", 32'(wrs), 32'(hit));
    idle_cycle();
  endtask

  initial begin
    rst          = 1'b1;
    MemReadM_i   = 1'b0;
    MemWriteM_i  = 3'b000;
    ALUResultM_i = '0;
    cache_hit_i  = 1'b0;
    mem_ready_i  = 1'b0;
    #2;
    chk("rst_req", 32'(mem_req_o), 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_we", 32'(mem_we_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    MemReadM_i = 1'b1;
    MemWriteM_i = 3'b011;
    #1;
    chk("rst_stall", 32'(StallAllM_o), 32'd0);
    chk("rst_wr", 32'(cache_wr_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 3; i++) load_hit(32'h100);
    load_miss(32'h204, 4);
    load_hit(32'h204);
    store(32'h300, 3'b010, 1'b1, 2);
    store(32'h300, 3'b010, 1'b0, 2);

    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      a = $urandom & 32'hFFFF_FFFC;
      case ($urandom_range(0, 4))
        0: idle_cycle();
        1: load_hit(a);
        2: load_miss(a, int'($urandom_range(1, 6)));
        3: store(a, 3'($urandom_range(1, 7)), 1'b1, int'($urandom_range(1, 6)));
        default: store(a, 3'($urandom_range(1, 7)), 1'b0, int'($urandom_range(1, 6)));
      endcase
    end

    load_miss(32'h40, TIMEOUT);
    chk("to_edge_no_err", 32'(err_o), 32'd0);
    store(32'h44, 3'b001, 1'b1, TIMEOUT);
    chk("to_edge_st_no_err", 32'(err_o), 32'd0);
    load_miss(32'h80, TIMEOUT + 6);
    chk("to_err_sticky", 32'(err_o), 32'd1);
    load_hit(32'h80);

    // Reset in the middle of a refill wait.
    MemReadM_i   = 1'b1;
    MemWriteM_i  = 3'b000;
    ALUResultM_i = 32'h208;
    cache_hit_i  = 1'b0;
    mem_ready_i  = 1'b0;
    step();
    settle();
    chk("ar_pre_req", 32'(mem_req_o), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("ar_req", 32'(mem_req_o), 32'd0);
    chk("ar_stall", 32'(StallAllM_o), 32'd0);
    chk("ar_err", 32'(err_o), 32'd0);
    exp_err = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    load_miss(32'h208, 3);
    idle_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
